mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Controller plus iterative datapath for the RV32M multiply/divide instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU, fed by the decoded funct3 and the register operands.
- Sequences a 32-step shift-add / restoring-divide engine and raises stall to freeze the PC and upstream state.
- Returns a one-cycle done pulse with the result for writeback.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; covers XLEN steps.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  M-type instruction present; held high by the pipeline until done.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  rs1 operand.
- SrcB  input  XLEN  rs2 operand.
- flush  input  1  abort current operation (branch/jump redirect).
- stall  output  1  freeze request to PC/fetch.
- busy  output  1  engine not IDLE.
- done  output  1  result valid, single-cycle pulse.
- MDUResult  output  XLEN  result; stable from done until next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; done=0, busy=0.
  - MDUResult=0, counter=0, internal registers=0.
  - Takes effect immediately, including mid-operation; no done is produced for an interrupted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0: capture funct3, SrcA, SrcB; record signs per op (signed: MULH, DIV, REM; rs1-signed only: MULHSU; else unsigned).
  - Convert operands to magnitudes; clear counter.
  - Special cases go straight to DONE instead of CALC:
    - SrcB=0 on a divide/remainder: quotient=all ones, remainder=SrcA.
    - Signed overflow DIV/REM with SrcA=0x80000000, SrcB=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- CALC:
  - One iteration per cycle, 32 cycles total (counter 0..31).
  - Multiply: 64-bit product accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract; 33-bit partial remainder, 32-bit quotient.
  - Counter=31 -> FIX.
- FIX (1 cycle):
  - Apply sign correction (two's complement negate) where required.
  - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
  - Quotient sign = signA XOR signB; remainder takes the sign of the dividend.
  - Register MDUResult -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
  - start is still high in this cycle but must not be re-accepted.
  - Re-arm requires start to be sampled in IDLE.
  - The pipeline deasserts start or advances to the next instruction on the done cycle.
- Latency:
  - start accepted at edge N; normal ops assert done in cycle N+34, i.e. 32 CALC + FIX + DONE.
  - Special cases assert done in cycle N+1.
- stall:
  - Combinational: (state==IDLE and start and not flush) or state in {CALC, FIX}.
  - Low in DONE, so the pipeline advances on the done cycle.
- busy = (state != IDLE).
- flush:
  - In CALC/FIX/DONE: state -> IDLE next edge.
  - done is forced 0 in the flush cycle; MDUResult is not updated.
  - flush in IDLE with start blocks acceptance.
  - flush has priority over every other transition.
- start while busy (not DONE) is ignored; operands are not re-sampled.
- Operand changes on SrcA/SrcB after acceptance have no effect.
- MUL result is independent of signedness; the low word is always taken.

Test Plan:
- Reset, then MUL SrcA=7, SrcB=0xFFFFFFFD -> stall high for cycles N..N+33, done at N+34, MDUResult=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all with done at N+34.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, done at N+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done at N+1.
- flush asserted in CALC cycle 10 -> busy=0 next cycle, no done pulse, MDUResult keeps previous value; new MUL 3×4 -> 12.
- rst_n pulsed low mid-CALC -> outputs 0 immediately; after release, IDLE and a DIVU 9/3 completes with 3.

Source files
------------

// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if : handshake/operand bundle between the pipeline and the RV32M
//          multiply/divide sequencer.
//
//   start     pipeline -> MDU  M-type instruction present, held until done
//   funct3    pipeline -> MDU  operation select (MUL..REMU)
//   SrcA      pipeline -> MDU  rs1 operand
//   SrcB      pipeline -> MDU  rs2 operand
//   flush     pipeline -> MDU  abort current operation (redirect)
//   stall     MDU -> pipeline  freeze PC/fetch
//   busy      MDU -> pipeline  engine not idle
//   done      MDU -> pipeline  single-cycle result-valid pulse
//   MDUResult MDU -> pipeline  writeback value
// ---------------------------------------------------------------------------
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] MDUResult;

    // Pipeline side
    modport master (
        output start, funct3, SrcA, SrcB, flush,
        input  stall, busy, done, MDUResult
    );

    // Multiply/divide unit side
    modport slave (
        input  start, funct3, SrcA, SrcB, flush,
        output stall, busy, done, MDUResult
    );
endinterface

// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer : iterative RV32M multiply/divide unit.
//
// A 32-step shift-add multiplier and a 32-step restoring divider share one
// operand/accumulator register set. Operands are converted to magnitudes on
// acceptance, iterated unsigned, and sign-corrected in a single FIX cycle.
// Divide-by-zero and signed overflow bypass the engine and complete at once.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mdu_if.slave : start/funct3/SrcA/SrcB/flush in,
//                         stall/busy/done/MDUResult out
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic              sign_a_reg, sign_b_reg;
    // Multiply: full 64-bit product, multiplier starts in the low half.
    // Divide:   low half holds the dividend, shifted out as quotient bits enter.
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   b_reg;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   rem_reg;    // partial remainder (always < divisor)
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   result_reg;

    // ------------------------------------------------------------------
    // Acceptance decode
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_div, div_zero, div_ovf, special;
    logic            a_signed, b_signed, in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a, mag_b, special_result;

    assign accept   = (state_reg == IDLE) && bus.start && !bus.flush;
    assign is_div   = bus.funct3[2];
    assign div_zero = is_div && (bus.SrcB == '0);
    // Only signed DIV/REM (funct3[0]==0) can overflow.
    assign div_ovf  = is_div && !bus.funct3[0]
                    && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.SrcB == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = bus.funct3[1] ? bus.SrcA : '1;
        else
            special_result = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2
    // as signed. MUL is handled unsigned since its low word is identical.
    assign a_signed  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                       (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                       (bus.funct3 == 3'b110);
    assign in_sign_a = a_signed && bus.SrcA[XLEN-1];
    assign in_sign_b = b_signed && bus.SrcB[XLEN-1];
    assign mag_a     = in_sign_a ? (~bus.SrcA + 1'b1) : bus.SrcA;
    assign mag_b     = in_sign_b ? (~bus.SrcB + 1'b1) : bus.SrcB;

    // ------------------------------------------------------------------
    // Iteration step logic
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next, quot_next;

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole product right keeping the carry.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                    + (acc_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide: 33-bit trial subtraction, keep it if non-negative.
    assign div_shift = {rem_reg, acc_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign q_bit     = !div_diff[XLEN];
    assign rem_next  = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quot_next = {acc_reg[XLEN-2:0], q_bit};

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[XLEN-1:0] + 1'b1)
                                                : acc_reg[XLEN-1:0];
    // Remainder follows the dividend's sign.
    assign rem_fix  = sign_a_reg ? (~rem_reg + 1'b1) : rem_reg;

    always_comb begin
        fix_result = '0;
        case (op_reg)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // FSM: next state (flush wins over every other transition)
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = special ? DONE : CALC;
            end
            CALC: begin
                if (bus.flush)
                    state_next = IDLE;
                else if (cnt_reg == CNT_W'(XLEN-1))
                    state_next = FIX;
            end
            FIX: begin
                state_next = bus.flush ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.stall     = accept || (state_reg == CALC) || (state_reg == FIX);
        bus.busy      = (state_reg != IDLE);
        bus.done      = (state_reg == DONE) && !bus.flush;
        bus.MDUResult = result_reg;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            acc_reg    <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= bus.funct3;
                        sign_a_reg <= in_sign_a;
                        sign_b_reg <= in_sign_b;
                        acc_reg    <= {{XLEN{1'b0}}, mag_a};
                        b_reg      <= mag_b;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        if (special)
                            result_reg <= special_result;
                    end
                end
                CALC: begin
                    if (!op_reg[2]) begin
                        acc_reg <= mul_next;
                    end else begin
                        acc_reg[XLEN-1:0] <= quot_next;
                        rem_reg           <= rem_next;
                    end
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                FIX: begin
                    if (!bus.flush)
                        result_reg <= fix_result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mdu_if #(.XLEN(32)) mif ();

    mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } sb_t;

    vec_t        vecs[16];
    sb_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp = 32'h0;
    string       op_name[8] = '{"MUL", "MULH", "MULHSU", "MULHU",
                                "DIV", "DIVU", "REM", "REMU"};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Independent reference built on the simulator's own arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ub64, p;
        logic signed [31:0] sa, sb, q;
        logic [31:0] r;
        logic ovf;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'd0, b};
        sa = a;
        sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = 32'h0;
        case (f)
            3'd0: begin p = sa64 * sb64; r = p[31:0]; end
            3'd1: begin p = sa64 * sb64; r = p[63:32]; end
            3'd2: begin p = sa64 * ub64; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * ub64; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin q = sa / sb; r = q; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin q = sa % sb; r = q; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Called just after a rising edge. Drives one instruction, pushes its
    // expectation, then waits (bounded) for done and checks timing/result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        sb_t e;
        sb_t got_e;
        int  k;
        bit  got;
        bit  stall_ok;
        mif.funct3 = f;
        mif.SrcA   = a;
        mif.SrcB   = b;
        mif.flush  = 1'b0;
        mif.start  = 1'b1;
        e.res = exp;
        e.lat = lat;
        exp_q.push_back(e);
        #1;
        check("stall_on_start", {31'd0, mif.stall}, 32'd1);
        @(posedge clk);
        #1;
        // Operands must have been captured; garbage from here on.
        mif.SrcA   = $urandom;
        mif.SrcB   = $urandom;
        mif.funct3 = 3'($urandom_range(0, 7));
        k = 1;
        got = 1'b0;
        stall_ok = 1'b1;
        while (!got && k <= 60) begin
            if (mif.done) begin
                got = 1'b1;
            end else begin
                if (mif.stall !== 1'b1) stall_ok = 1'b0;
                @(posedge clk);
                #1;
                k++;
            end
        end
        got_e = exp_q.pop_front();
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL done_timeout: %s no done within 60 cycles, expected at %0d",
                     op_name[f], got_e.lat);
        end else begin
            $display("[TB] %s a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) latency %0d",
                     op_name[f], a, b, mif.MDUResult, got_e.res, k);
            check("latency", k, got_e.lat);
            check("result", mif.MDUResult, got_e.res);
            check("stall_while_busy", {31'd0, stall_ok}, 32'd1);
            check("stall_in_done", {31'd0, mif.stall}, 32'd0);
            last_exp = got_e.res;
        end
        // start still high across the DONE->IDLE edge: must not re-launch.
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, mif.done}, 32'd0);
        check("idle_after_done", {31'd0, mif.busy}, 32'd0);
        check("result_held", mif.MDUResult, last_exp);
        mif.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'h0000_1234,  32'd0,         32'h0000_1234, 1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 34};
        vecs[13] = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[15] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};

        mif.start  = 1'b0;
        mif.flush  = 1'b0;
        mif.funct3 = 3'd0;
        mif.SrcA   = 32'h0;
        mif.SrcB   = 32'h0;

        // Reset state
        #2;
        check("rst_done", {31'd0, mif.done}, 32'd0);
        check("rst_busy", {31'd0, mif.busy}, 32'd0);
        check("rst_result", mif.MDUResult, 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {31'd0, mif.busy}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 16; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Random vectors against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 8; f++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
                run_op(3'(f), a, b, ref_mdu(3'(f), a, b), ref_lat(3'(f), a, b));
            end
        end

        // flush in IDLE with start blocks acceptance
        mif.funct3 = 3'd0; mif.SrcA = 32'd9; mif.SrcB = 32'd9;
        mif.start = 1'b1; mif.flush = 1'b1;
        #1;
        check("flush_idle_stall", {31'd0, mif.stall}, 32'd0);
        @(posedge clk);
        #1;
        check("flush_idle_busy", {31'd0, mif.busy}, 32'd0);
        mif.start = 1'b0; mif.flush = 1'b0;
        $display("[TB] flush in IDLE: busy=%0d", mif.busy);

        // flush mid-CALC: abort, no done, result unchanged
        begin
            bit saw_done;
            mif.funct3 = 3'd0; mif.SrcA = 32'h1234; mif.SrcB = 32'h5678;
            mif.start = 1'b1;
            @(posedge clk);
            #1;
            repeat (9) begin @(posedge clk); #1; end
            mif.flush = 1'b1; mif.start = 1'b0;
            #1;
            check("flush_calc_done", {31'd0, mif.done}, 32'd0);
            @(posedge clk);
            #1;
            mif.flush = 1'b0;
            check("flush_calc_busy", {31'd0, mif.busy}, 32'd0);
            saw_done = 1'b0;
            repeat (40) begin
                if (mif.done) saw_done = 1'b1;
                @(posedge clk);
                #1;
            end
            check("flush_no_done", {31'd0, saw_done}, 32'd0);
            check("flush_result_kept", mif.MDUResult, last_exp);
            $display("[TB] flush in CALC: result=0x%08h (exp 0x%08h)", mif.MDUResult, last_exp);
        end
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 34);

        // flush in DONE forces done low
        mif.funct3 = 3'd5; mif.SrcA = 32'h55; mif.SrcB = 32'h0;
        mif.start = 1'b1;
        @(posedge clk);
        #1;
        mif.flush = 1'b1;
        #1;
        check("flush_done_pulse", {31'd0, mif.done}, 32'd0);
        @(posedge clk);
        #1;
        mif.flush = 1'b0; mif.start = 1'b0;
        check("flush_done_busy", {31'd0, mif.busy}, 32'd0);
        $display("[TB] flush in DONE: busy=%0d", mif.busy);

        // Async reset mid-CALC
        mif.funct3 = 3'd5; mif.SrcA = 32'd100; mif.SrcB = 32'd7;
        mif.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) begin @(posedge clk); #1; end
        check("pre_rst_busy", {31'd0, mif.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        mif.start = 1'b0;
        #1;
        check("arst_busy", {31'd0, mif.busy}, 32'd0);
        check("arst_done", {31'd0, mif.done}, 32'd0);
        check("arst_stall", {31'd0, mif.stall}, 32'd0);
        check("arst_result", mif.MDUResult, 32'd0);
        $display("[TB] async reset mid-CALC: busy=%0d result=0x%08h", mif.busy, mif.MDUResult);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, mif.busy}, 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 34);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
